// File: rtl/rng_share_arbiter_if.sv
// Requester-side bundle of the shared random-number arbiter.
//   req       : per-requester level request, held until its handshake completes
//   rsp_valid : one-hot, a value is waiting for that requester
//   rsp_ready : per-requester accept (only the granted bit is honoured)
//   rsp_data  : delivered value, shared by all requesters
// slave  : the arbiter side
// master : the requester side
interface rng_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] rsp_valid;
    logic [NUM_REQ-1:0] rsp_ready;
    logic [WIDTH-1:0]   rsp_data;

    modport slave (
        input  req,
        input  rsp_ready,
        output rsp_valid,
        output rsp_data
    );

    modport master (
        output req,
        output rsp_ready,
        input  rsp_valid,
        input  rsp_data
    );
endinterface

// File: rtl/rng_share_arbiter.sv
// Round-robin sharing of one registered random source between NUM_REQ
// requesters, with per-requester range bounding by mask-and-reject.
//   clk, rst_n            : clock, asynchronous active-low reset
//   rsp_if (slave)        : req / rsp_valid / rsp_ready / rsp_data
//   rng_enable            : one-cycle enable pulse to the random source
//   rng_number            : registered source output, new value the edge after enable
//   cfg_we/cfg_idx/cfg_bound : bound register write (exclusive bound, 0 = full range)
//   busy                  : FSM not idle
//   rej_count             : saturating count of rejected draws
//
// state   | meaning
// IDLE    | wait for any req, pick round-robin, latch index and bound
// DRAW    | rng_enable high for this single cycle
// WAIT    | source output now valid, capture it
// CHECK   | mask and range-test; accept -> DELIVER, reject -> DRAW
// DELIVER | hold value until the granted requester accepts
module rng_share_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 32,
    parameter int REJ_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rng_share_arbiter_if.slave   rsp_if,
    output logic                 rng_enable,
    input  logic [WIDTH-1:0]     rng_number,
    input  logic                 cfg_we,
    input  logic [2:0]           cfg_idx,
    input  logic [WIDTH-1:0]     cfg_bound,
    output logic                 busy,
    output logic [REJ_CNT_W-1:0] rej_count
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {IDLE, DRAW, WAIT, CHECK, DELIVER} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   bound [NUM_REQ];
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   gnt_idx;
    logic [WIDTH-1:0]   lbound;
    logic [WIDTH-1:0]   raw;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [WIDTH-1:0]   mask;
    logic [WIDTH-1:0]   masked;
    logic               in_range;
    logic               hs_done;

    // Circular scan starting at rr_ptr; first requesting index wins.
    always_comb begin
        int c;
        c          = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            c = int'(rr_ptr) + i;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            if (!pick_found && rsp_if.req[IDX_W'(c)]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(c);
            end
        end
    end

    // Smearing lbound-1 downward gives 2^k-1 for the smallest 2^k >= lbound
    // (lbound = 1 yields 0). lbound = 0 wraps to all ones, i.e. no masking.
    always_comb begin
        mask = lbound - 1'b1;
        for (int i = WIDTH - 2; i >= 0; i--) begin
            mask[i] = mask[i] | mask[i+1];
        end
        masked   = raw & mask;
        in_range = (lbound == '0) || (masked < lbound);
    end

    assign hs_done = rsp_if.rsp_ready[gnt_idx];

    always_comb begin
        state_nxt  = state;
        rng_enable = 1'b0;
        case (state)
            IDLE:    if (pick_found) state_nxt = DRAW;
            DRAW: begin
                rng_enable = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT:    state_nxt = CHECK;
            CHECK:   state_nxt = in_range ? DELIVER : DRAW;
            DELIVER: if (hs_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            gnt_idx          <= '0;
            lbound           <= '0;
            raw              <= '0;
            rsp_if.rsp_valid <= '0;
            rsp_if.rsp_data  <= '0;
            rej_count        <= '0;
            for (int i = 0; i < NUM_REQ; i++) bound[i] <= '0;
        end else begin
            state <= state_nxt;

            if (cfg_we && (int'(cfg_idx) < NUM_REQ))
                bound[cfg_idx[IDX_W-1:0]] <= cfg_bound;

            case (state)
                IDLE: begin
                    if (pick_found) begin
                        gnt_idx <= pick_idx;
                        lbound  <= bound[pick_idx];
                    end
                end
                WAIT: raw <= rng_number;
                CHECK: begin
                    if (in_range) begin
                        rsp_if.rsp_data  <= masked;
                        rsp_if.rsp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx;
                    end else if (rej_count != {REJ_CNT_W{1'b1}}) begin
                        rej_count <= rej_count + 1'b1;
                    end
                end
                DELIVER: begin
                    if (hs_done) begin
                        rsp_if.rsp_valid <= '0;
                        rr_ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rng_share_arbiter.sv
// Directed bench for rng_share_arbiter. The random source is modelled by a
// queue popped on each sampled rng_enable (fill_val once the queue is empty).
// The rejection counter is built 8 bits wide here so saturation is reached
// within a short run; the saturating logic is width-independent.
module tb_rng_share_arbiter;
    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 32;
    localparam int REJ_W   = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             rng_enable;
    logic [WIDTH-1:0] rng_number = '0;
    logic             cfg_we = 1'b0;
    logic [2:0]       cfg_idx = '0;
    logic [WIDTH-1:0] cfg_bound = '0;
    logic             busy;
    logic [REJ_W-1:0] rej_count;

    rng_share_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) rsp_if ();

    rng_share_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .REJ_CNT_W(REJ_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rsp_if     (rsp_if.slave),
        .rng_enable (rng_enable),
        .rng_number (rng_number),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_bound  (cfg_bound),
        .busy       (busy),
        .rej_count  (rej_count)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] rng_q[$];
    logic [WIDTH-1:0] fill_val = '0;
    int               enable_cnt = 0;

    always @(posedge clk) begin
        if (rng_enable) begin
            if (rng_q.size() > 0) rng_number <= rng_q.pop_front();
            else                  rng_number <= fill_val;
            enable_cnt <= enable_cnt + 1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input string tag, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (rsp_if.rsp_valid == '0 && cyc < 200);
        check({tag, " timeout"}, 64'(rsp_if.rsp_valid == '0), 64'd0);
    endtask

    task automatic finish_hs(input logic [NUM_REQ-1:0] r);
        rsp_if.rsp_ready = r;
        @(negedge clk);
        check("valid cleared after handshake", 64'(rsp_if.rsp_valid), 64'd0);
        rsp_if.rsp_ready = '0;
        rsp_if.req       = rsp_if.req & ~r;
    endtask

    task automatic cfg_write(input logic [2:0] idx, input logic [WIDTH-1:0] val);
        cfg_we    = 1'b1;
        cfg_idx   = idx;
        cfg_bound = val;
        @(negedge clk);
        cfg_we    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        rsp_if.req       = '0;
        rsp_if.rsp_ready = '0;
        cfg_we           = 1'b0;
        rng_q.delete();
        fill_val         = '0;
        repeat (2) @(negedge clk);
        check("reset valid", 64'(rsp_if.rsp_valid), 64'd0);
        check("reset data",  64'(rsp_if.rsp_data),  64'd0);
        check("reset busy",  64'(busy),             64'd0);
        check("reset rej",   64'(rej_count),        64'd0);
        check("reset en",    64'(rng_enable),       64'd0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        int e0;
        logic [REJ_W-1:0] r0;

        rsp_if.req       = '0;
        rsp_if.rsp_ready = '0;
        do_reset();

        // Unbounded single draw, minimum latency
        rng_q.push_back(32'hDEADBEEF);
        rsp_if.req = 4'b0001;
        repeat (3) @(negedge clk);
        check("t1 valid before cycle 4", 64'(rsp_if.rsp_valid), 64'd0);
        @(negedge clk);
        check("t1 valid",   64'(rsp_if.rsp_valid), 64'h1);
        check("t1 data",    64'(rsp_if.rsp_data),  64'hDEADBEEF);
        check("t1 rej",     64'(rej_count),        64'd0);
        check("t1 busy",    64'(busy),             64'd1);
        check("t1 enables", 64'(enable_cnt),       64'd1);
        finish_hs(4'b0001);

        // Bound 10 -> mask 15: 0xC rejected, 7 accepted
        cfg_write(3'd1, 32'd10);
        rng_q.push_back(32'h0000000C);
        rng_q.push_back(32'h00000007);
        e0 = enable_cnt;
        rsp_if.req = 4'b0010;
        wait_valid("t2", cyc);
        check("t2 valid",   64'(rsp_if.rsp_valid), 64'h2);
        check("t2 data",    64'(rsp_if.rsp_data),  64'd7);
        check("t2 rej",     64'(rej_count),        64'd1);
        check("t2 enables", 64'(enable_cnt - e0),  64'd2);
        finish_hs(4'b0010);

        // Round-robin with all requesting, back-to-back spacing
        do_reset();
        for (int i = 0; i < 5; i++) rng_q.push_back(32'(100 + i));
        rsp_if.req       = 4'b1111;
        rsp_if.rsp_ready = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_valid("t3", cyc);
            check("t3 grant", 64'(rsp_if.rsp_valid), 64'(4'b0001 << (i % 4)));
            check("t3 data",  64'(rsp_if.rsp_data),  64'(100 + i));
            if (i > 0) check("t3 spacing", 64'(cyc), 64'd5);
        end
        @(negedge clk);
        rsp_if.req       = '0;
        rsp_if.rsp_ready = '0;

        // Requester 2 stalls 5 cycles; other ready bits must be ignored
        rng_q.push_back(32'h2222AAAA);
        rsp_if.req = 4'b0100;
        wait_valid("t4", cyc);
        e0 = enable_cnt;
        rsp_if.rsp_ready = 4'b1011;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4 hold valid", 64'(rsp_if.rsp_valid), 64'h4);
            check("t4 hold data",  64'(rsp_if.rsp_data),  64'h2222AAAA);
            check("t4 no enable",  64'(enable_cnt - e0),  64'd0);
        end
        finish_hs(4'b0100);
        rng_q.push_back(32'h33333333);
        rsp_if.req = 4'b1011;
        wait_valid("t4b", cyc);
        check("t4 rr after hs", 64'(rsp_if.rsp_valid), 64'h8);
        finish_hs(4'b1000);
        rsp_if.req = '0;

        // Bound write during WAIT affects only the next grant
        rng_q.push_back(32'hFFFFFFFE);
        rsp_if.req = 4'b0001;
        @(negedge clk);
        check("t5 draw pulse", 64'(rng_enable), 64'd1);
        @(negedge clk);
        cfg_write(3'd0, 32'd3);
        r0 = rej_count;
        wait_valid("t5", cyc);
        check("t5 unmasked", 64'(rsp_if.rsp_data), 64'hFFFFFFFE);
        check("t5 rej",      64'(rej_count - r0),  64'd0);
        finish_hs(4'b0001);
        rng_q.push_back(32'h00000003);
        rng_q.push_back(32'h00000006);
        rsp_if.req = 4'b0001;
        wait_valid("t5b", cyc);
        check("t5 masked data", 64'(rsp_if.rsp_data), 64'd2);
        check("t5 rej 3",       64'(rej_count - r0),  64'd1);
        finish_hs(4'b0001);

        // Async reset in CHECK, then in DELIVER
        rng_q.push_back(32'h55555555);
        rsp_if.req = 4'b0010;
        repeat (3) @(negedge clk);
        check("t6 busy pre", 64'(busy), 64'd1);
        rst_n = 1'b0;
        rsp_if.req = '0;
        #1;
        check("t6 chk busy",  64'(busy),             64'd0);
        check("t6 chk valid", 64'(rsp_if.rsp_valid), 64'd0);
        check("t6 chk rej",   64'(rej_count),        64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rng_q.delete();
        rng_q.push_back(32'hABCD1234);
        rsp_if.req = 4'b1001;
        wait_valid("t6", cyc);
        check("t6 rr restart", 64'(rsp_if.rsp_valid), 64'h1);
        check("t6 bound reset", 64'(rsp_if.rsp_data), 64'hABCD1234);
        rst_n = 1'b0;
        #1;
        check("t6 dlv valid", 64'(rsp_if.rsp_valid), 64'd0);
        check("t6 dlv data",  64'(rsp_if.rsp_data),  64'd0);
        check("t6 dlv busy",  64'(busy),             64'd0);
        rsp_if.req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Out-of-range cfg index ignored; bound 1 forces zero
        cfg_write(3'd4, 32'd2);
        rng_q.push_back(32'hFFFFFFF5);
        rsp_if.req = 4'b0001;
        wait_valid("t7", cyc);
        check("t7 idx4 ignored", 64'(rsp_if.rsp_data), 64'hFFFFFFF5);
        finish_hs(4'b0001);
        cfg_write(3'd1, 32'd1);
        rng_q.push_back(32'hFFFFFFFF);
        rsp_if.req = 4'b0010;
        wait_valid("t7b", cyc);
        check("t7 bound1 data", 64'(rsp_if.rsp_data), 64'd0);
        check("t7 bound1 rej",  64'(rej_count),       64'd0);
        finish_hs(4'b0010);

        // Rejection counter saturation: bound 5, source stuck at 7
        cfg_write(3'd2, 32'd5);
        fill_val = 32'd7;
        rsp_if.req = 4'b0100;
        repeat (1000) @(negedge clk);
        check("t8 rej saturated", 64'(rej_count),        64'hFF);
        check("t8 no valid",      64'(rsp_if.rsp_valid), 64'd0);
        check("t8 busy",          64'(busy),             64'd1);
        fill_val = 32'd4;
        wait_valid("t8", cyc);
        check("t8 data",     64'(rsp_if.rsp_data), 64'd4);
        check("t8 rej held", 64'(rej_count),       64'hFF);
        finish_hs(4'b0100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
